// File: rtl/mux_arb_rr.sv
// mux_arb_rr: N_CH-way, DW-bit registered multiplexer with round-robin
// arbitration and valid/ready handshakes on every input and on the output.
// One output register stage gives one cycle of latency, and a full-rate
// drain-and-refill needs no bubble.
// Optional packet lock: define MUX_ARB_LOCK_EN to add i_last/o_last and keep
// the grant on one channel until the beat that has i_last set.
module mux_arb_rr #(
  parameter int N_CH = 4,
  parameter int DW   = 32,
  localparam int SW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_CH-1:0]   i_valid,
  input  logic [N_CH*DW-1:0] i_data,
  output logic [N_CH-1:0]   o_ready,
  output logic              o_valid,
  output logic [DW-1:0]     o_data,
  output logic [SW-1:0]     o_sel,
  input  logic              i_ready
`ifdef MUX_ARB_LOCK_EN
  ,
  input  logic [N_CH-1:0]   i_last,
  output logic              o_last
`endif
);

  logic          o_valid_q;
  logic [DW-1:0] o_data_q;
  logic [SW-1:0] o_sel_q;
  logic [SW-1:0] ptr_q;
  logic [SW-1:0] next_ptr;

  logic          load;
  logic          win_found;
  logic [SW-1:0] win_idx;
  int unsigned   scan_idx;

  logic          lock_active;
  logic          beat_last;

`ifdef MUX_ARB_LOCK_EN
  logic lock_q;
  logic o_last_q;

  assign lock_active = lock_q;
  assign beat_last   = i_last[win_idx];
  assign o_last      = o_last_q;
`else
  // Without the lock every beat is its own packet.
  assign lock_active = 1'b0;
  assign beat_last   = 1'b1;
`endif

  // The output register may take a new beat when empty or being drained.
  assign load = !o_valid_q | i_ready;

  // Wrap after the highest real channel so ptr never holds an unused index.
  assign next_ptr = (win_idx == SW'(N_CH - 1)) ? '0 : win_idx + SW'(1);

  // Round-robin scan from ptr; a held lock pins the grant to the locked channel.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= N_CH) scan_idx = scan_idx - N_CH;
      if (!win_found && i_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[SW-1:0];
      end
    end
    if (lock_active) begin
      win_found = i_valid[o_sel_q];
      win_idx   = o_sel_q;
    end
  end

  // Accept strobe for the winner only; held low throughout reset.
  always_comb begin
    o_ready = '0;
    if (!i_rst && load && win_found) o_ready[win_idx] = 1'b1;
  end

  // Output register and round-robin pointer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_sel_q   <= '0;
      ptr_q     <= '0;
    end else if (load) begin
      if (win_found) begin
        o_valid_q <= 1'b1;
        o_data_q  <= i_data[int'(win_idx)*DW +: DW];
        o_sel_q   <= win_idx;
        if (beat_last) ptr_q <= next_ptr;
      end else begin
        o_valid_q <= 1'b0;
      end
    end
  end

`ifdef MUX_ARB_LOCK_EN
  // Packet lock state and the registered last flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lock_q   <= 1'b0;
      o_last_q <= 1'b0;
    end else if (load && win_found) begin
      lock_q   <= !beat_last;
      o_last_q <= beat_last;
    end
  end
`endif

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_sel   = o_sel_q;

endmodule

// File: tb/tb_mux_arb_rr.sv
// Directed testbench for mux_arb_rr (N_CH=4, DW=32).
module tb_mux_arb_rr;

  localparam int N_CH = 4;
  localparam int DW   = 32;
  localparam int SW   = 2;

  logic              i_clk;
  logic              i_rst;
  logic [N_CH-1:0]   i_valid;
  logic [N_CH*DW-1:0] i_data;
  logic [N_CH-1:0]   o_ready;
  logic              o_valid;
  logic [DW-1:0]     o_data;
  logic [SW-1:0]     o_sel;
  logic              i_ready;
`ifdef MUX_ARB_LOCK_EN
  logic [N_CH-1:0]   i_last;
  logic              o_last;
`endif

  int checks;
  int errors;

  logic [DW+SW:0] st;
  logic [DW+SW:0] exp_st;
  logic [N_CH-1:0] exp_rdy;

  mux_arb_rr #(.N_CH(N_CH), .DW(DW)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_sel   (o_sel),
    .i_ready (i_ready)
`ifdef MUX_ARB_LOCK_EN
    ,
    .i_last  (i_last),
    .o_last  (o_last)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  assign st = {o_valid, o_sel, o_data};

  task automatic do_reset();
    i_rst   = 1'b1;
    i_valid = '0;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_rst   = 1'b1;
    i_ready = 1'b1;
    i_valid = 4'b1111;
    #1;
    checks++;
    if (o_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ready_gated: got %b expected 0000", o_ready);
    end
    step();
    checks++;
    if (st !== {1'b0, 2'd0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", st, {1'b0, 2'd0, 32'h0});
    end
    i_valid = '0;
    i_rst   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (st !== {1'b0, 2'd0, 32'h0} || o_ready !== 4'b0000) begin
        errors++;
        $display("FAIL idle_cycle%0d: got st=%h rdy=%b expected st=0 rdy=0000", c, st, o_ready);
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    i_valid = 4'b1111;
    #1;
    checks++;
    if (o_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rr_first_ready: got %b expected 0001", o_ready);
    end
    for (int j = 0; j < 5; j++) begin
      step();
      exp_st  = {1'b1, SW'(j % 4), 32'hA0 + 32'(j % 4)};
      exp_rdy = 4'b0001 << ((j + 1) % 4);
      checks++;
      if (st !== exp_st || o_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rr_grant%0d: got st=%h rdy=%b expected st=%h rdy=%b", j, st, o_ready, exp_st, exp_rdy);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    i_valid = 4'b0101;
    step();
    i_ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (st !== {1'b1, 2'd0, 32'hA0} || o_ready !== 4'b0000) begin
        errors++;
        $display("FAIL stall_hold%0d: got st=%h rdy=%b expected st=%h rdy=0000", c, st, o_ready, {1'b1, 2'd0, 32'hA0});
      end
      step();
    end
    i_ready = 1'b1;
    #1;
    checks++;
    if (o_ready !== 4'b0100) begin
      errors++;
      $display("FAIL stall_release_ready: got %b expected 0100", o_ready);
    end
    step();
    checks++;
    if (st !== {1'b1, 2'd2, 32'hA2}) begin
      errors++;
      $display("FAIL stall_grant_ch2: got %h expected %h", st, {1'b1, 2'd2, 32'hA2});
    end
    step();
    checks++;
    if (st !== {1'b1, 2'd0, 32'hA0}) begin
      errors++;
      $display("FAIL stall_grant_ch0: got %h expected %h", st, {1'b1, 2'd0, 32'hA0});
    end
  endtask

  task automatic test_wrap();
    do_reset();
    i_valid = 4'b1000;
    #1;
    checks++;
    if (o_ready !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_ready_ch3: got %b expected 1000", o_ready);
    end
    step();
    i_valid = 4'b0000;
    step();
    checks++;
    if (st !== {1'b0, 2'd3, 32'hA3}) begin
      errors++;
      $display("FAIL wrap_empty_hold: got %h expected %h", st, {1'b0, 2'd3, 32'hA3});
    end
    i_valid = 4'b1001;
    #1;
    checks++;
    if (o_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_ptr_zero: got %b expected 0001", o_ready);
    end
    step();
    checks++;
    if (st !== {1'b1, 2'd0, 32'hA0} || o_ready !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_grant_ch0: got st=%h rdy=%b expected st=%h rdy=1000", st, o_ready, {1'b1, 2'd0, 32'hA0});
    end
    i_valid = 4'b0001;
    #1;
    checks++;
    if (o_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_b2b_ready: got %b expected 0001", o_ready);
    end
    step();
    checks++;
    if (st !== {1'b1, 2'd0, 32'hA0}) begin
      errors++;
      $display("FAIL wrap_b2b_grant: got %h expected %h", st, {1'b1, 2'd0, 32'hA0});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_valid = 4'b1111;
    step();
    step();
    checks++;
    if (st !== {1'b1, 2'd1, 32'hA1} || o_ready !== 4'b0100) begin
      errors++;
      $display("FAIL mid_pre_reset: got st=%h rdy=%b expected st=%h rdy=0100", st, o_ready, {1'b1, 2'd1, 32'hA1});
    end
    #1;
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 4'b0000) begin
      errors++;
      $display("FAIL mid_async_reset: got valid=%b rdy=%b expected valid=0 rdy=0000", o_valid, o_ready);
    end
    step();
    i_rst = 1'b0;
    #1;
    checks++;
    if (o_ready !== 4'b0001) begin
      errors++;
      $display("FAIL mid_release_ready: got %b expected 0001", o_ready);
    end
    step();
    checks++;
    if (st !== {1'b1, 2'd0, 32'hA0}) begin
      errors++;
      $display("FAIL mid_first_grant: got %h expected %h", st, {1'b1, 2'd0, 32'hA0});
    end
  endtask

`ifdef MUX_ARB_LOCK_EN
  task automatic test_lock();
    i_last = 4'b1101;
    do_reset();
    i_valid = 4'b0111;
    step();
    step();
    checks++;
    if (st !== {1'b1, 2'd1, 32'hA1} || o_last !== 1'b0) begin
      errors++;
      $display("FAIL lock_beat1: got st=%h last=%b expected st=%h last=0", st, o_last, {1'b1, 2'd1, 32'hA1});
    end
    i_valid = 4'b0101;
    #1;
    checks++;
    if (o_ready !== 4'b0000) begin
      errors++;
      $display("FAIL lock_block_others: got %b expected 0000", o_ready);
    end
    i_valid = 4'b0111;
    step();
    checks++;
    if (st !== {1'b1, 2'd1, 32'hA1} || o_last !== 1'b0) begin
      errors++;
      $display("FAIL lock_beat2: got st=%h last=%b expected st=%h last=0", st, o_last, {1'b1, 2'd1, 32'hA1});
    end
    i_last = 4'b1111;
    step();
    checks++;
    if (st !== {1'b1, 2'd1, 32'hA1} || o_last !== 1'b1) begin
      errors++;
      $display("FAIL lock_beat3: got st=%h last=%b expected st=%h last=1", st, o_last, {1'b1, 2'd1, 32'hA1});
    end
    step();
    checks++;
    if (st !== {1'b1, 2'd2, 32'hA2}) begin
      errors++;
      $display("FAIL lock_next_ch2: got %h expected %h", st, {1'b1, 2'd2, 32'hA2});
    end
  endtask
`endif

  initial begin
    checks  = 0;
    errors  = 0;
    i_rst   = 1'b1;
    i_valid = '0;
    i_ready = 1'b1;
    for (int k = 0; k < N_CH; k++) i_data[k*DW +: DW] = 32'hA0 + 32'(k);
`ifdef MUX_ARB_LOCK_EN
    i_last = '1;
`endif
    #2;
    test_reset();
    test_round_robin();
    test_stall();
    test_wrap();
    test_reset_mid();
`ifdef MUX_ARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
